// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the serial BCD adder controller.
// Carries the valid/ready operand side and the valid/ready result side.
interface bcd_serial_add_ctrl_if #(
   parameter int W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [4*W-1:0]   x;
   logic [4*W-1:0]   y;
   logic             acc;
   logic             out_valid;
   logic             out_ready;
   logic [4*W+3:0]   z;
   logic             err;

   modport master (
      output in_valid, x, y, acc, out_ready,
      input  in_ready, out_valid, z, err
   );

   modport slave (
      input  in_valid, x, y, acc, out_ready,
      output in_ready, out_valid, z, err
   );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder: one shared digit cell, LSD first, W clocks accept-to-result.
// in_ready only in IDLE, result held in DONE until out_ready; both decoded from state.
module bcd_serial_add_ctrl #(
   parameter int W = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   bcd_serial_add_ctrl_if.slave  bus
);
   localparam int KW = (W > 1) ? $clog2(W) : 1;
   localparam logic [KW-1:0] LAST = KW'(W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [4*W-1:0]  r_x;
   logic [4*W-1:0]  r_y;
   logic [4*W+3:0]  r_z;
   logic            r_err;
   logic            r_c;
   logic [KW-1:0]   r_k;

   logic            w_accept;
   logic            w_last;
   logic [4*W-1:0]  w_cap_x;
   logic            w_cap_err;
   logic [3:0]      w_xk;
   logic [3:0]      w_yk;
   logic [4:0]      w_s;
   logic            w_cor;
   logic [3:0]      w_zk;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_accept      = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               w_accept = 1'b1;
               w_next   = RUN;
            end
         end
         RUN: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // In accumulate mode the running total's carry digit is dropped.
   assign w_cap_x = bus.acc ? r_z[4*W-1:0] : bus.x;

   always_comb begin
      w_cap_err = 1'b0;
      for (int i = 0; i < W; i++) begin
         w_cap_err = w_cap_err | (w_cap_x[4*i +: 4] > 4'd9) | (bus.y[4*i +: 4] > 4'd9);
      end
   end

   assign w_last = (r_k == LAST);
   assign w_xk   = r_x[4*r_k +: 4];
   assign w_yk   = r_y[4*r_k +: 4];
   assign w_s    = {1'b0, w_xk} + {1'b0, w_yk} + {4'b0000, r_c};
   assign w_cor  = w_s[4] | (w_s[3] & w_s[2]) | (w_s[3] & w_s[1]);
   assign w_zk   = w_s[3:0] + (w_cor ? 4'd6 : 4'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x   <= '0;
         r_y   <= '0;
         r_z   <= '0;
         r_err <= 1'b0;
         r_c   <= 1'b0;
         r_k   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x   <= w_cap_x;
                  r_y   <= bus.y;
                  r_err <= w_cap_err;
                  r_c   <= 1'b0;
                  r_k   <= '0;
               end
            end
            RUN: begin
               r_z[4*r_k +: 4] <= w_zk;
               r_c             <= w_cor;
               r_k             <= r_k + KW'(1);
               if (w_last) r_z[4*W +: 4] <= {3'b000, w_cor};
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.z   = r_z;
   assign bus.err = r_err;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (W=3) with hand-computed sums.
module tb_bcd_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   bcd_serial_add_ctrl_if #(.W(3)) bus ();

   bcd_serial_add_ctrl #(.W(3)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic op(input string tag, input logic [11:0] xv, input logic [11:0] yv,
                     input logic accv, input logic [15:0] ez, input logic eerr,
                     input int stall);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.x        = xv;
      bus.y        = yv;
      bus.acc      = accv;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.x        = '0;
      bus.y        = '0;
      bus.acc      = 1'b0;
      chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd3);
      chk({tag, "_z"}, 32'(bus.z), 32'(ez));
      chk({tag, "_err"}, 32'(bus.err), 32'(eerr));
      for (int s = 0; s < stall; s++) begin
         bus.in_valid = 1'b1;
         bus.x        = 12'h111;
         bus.y        = 12'h222;
         @(posedge clk); #1;
         chk({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
         chk({tag, "_hold_z"}, 32'(bus.z), 32'(ez));
         chk({tag, "_hold_err"}, 32'(bus.err), 32'(eerr));
         chk({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, "_done_vld"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_done_rdy"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.acc       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_z", 32'(bus.z), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op("a543_220", 12'h543, 12'h220, 1'b0, 16'h0763, 1'b0, 0);
      op("a817_523", 12'h817, 12'h523, 1'b0, 16'h1340, 1'b0, 0);
      op("a999_999", 12'h999, 12'h999, 1'b0, 16'h1998, 1'b0, 0);
      op("stall999", 12'h999, 12'h999, 1'b0, 16'h1998, 1'b0, 5);
      op("acc_seed", 12'h500, 12'h000, 1'b0, 16'h0500, 1'b0, 0);
      op("acc_600",  12'h000, 12'h600, 1'b1, 16'h1100, 1'b0, 0);
      op("acc_001",  12'h777, 12'h001, 1'b1, 16'h0101, 1'b0, 0);
      op("bad_digit", 12'h00A, 12'h001, 1'b0, 16'h0011, 1'b1, 0);

      bus.in_valid = 1'b1;
      bus.x        = 12'h123;
      bus.y        = 12'h456;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.x        = '0;
      bus.y        = '0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrun_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrun_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrun_z", 32'(bus.z), 32'd0);
      chk("midrun_err", 32'(bus.err), 32'd0);
      #2;
      rst_n = 1'b1;

      op("post_1_1", 12'h001, 12'h001, 1'b0, 16'h0002, 1'b0, 0);
      op("post_acc", 12'h000, 12'h007, 1'b1, 16'h0009, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
